// File: rtl/lfsr_prbs_sequencer_pkg.sv
// Shared constants and state encoding for the PRBS byte sequencer.
package lfsr_prbs_sequencer_pkg;

  localparam int LFSR_BITS = 32;
  localparam int BITS_PER_BYTE = 8;
  localparam logic [LFSR_BITS-1:0] LFSR_LOCKUP = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // An all-ones seed would freeze an XNOR LFSR, so swap in a safe value.
  function automatic logic [LFSR_BITS-1:0] safe_seed(
    input logic [LFSR_BITS-1:0] seed,
    input logic [LFSR_BITS-1:0] fallback
  );
    return (seed == LFSR_LOCKUP) ? fallback : seed;
  endfunction

endpackage

// File: rtl/lfsr_prbs_sequencer_lfsr.sv
// Fibonacci XNOR LFSR: shifts left, feedback enters at bit 0; synchronous seed load.
module lfsr #(
  parameter int NUM_BITS = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_seed,
  input  logic                i_enable,
  input  logic [NUM_BITS-1:0] i_seed_data,
  output logic [NUM_BITS-1:0] o_lfsr_data
);

  function automatic logic [NUM_BITS-1:0] tap_mask();
    case (NUM_BITS)
      8:       return NUM_BITS'(32'h0000_00B8);
      16:      return NUM_BITS'(32'h0000_D008);
      default: return NUM_BITS'(32'h8020_0003);
    endcase
  endfunction

  localparam logic [NUM_BITS-1:0] TAPS = tap_mask();

  logic [NUM_BITS-1:0] lfsr_q;
  logic                feedback;

  // XNOR of all taps equals inverted parity; all-ones is the lock-up state.
  assign feedback = ~^(lfsr_q & TAPS);

  always_ff @(posedge i_clk) begin
    if (i_rst_seed) begin
      lfsr_q <= i_seed_data;
    end else if (i_enable) begin
      lfsr_q <= {lfsr_q[NUM_BITS-2:0], feedback};
    end
  end

  assign o_lfsr_data = lfsr_q;

endmodule

// File: rtl/lfsr_prbs_sequencer.sv
// Seeds the shared LFSR, steps it eight shifts per byte and streams a bounded
// PRBS burst over a valid/ready byte interface.
module lfsr_prbs_sequencer #(
  parameter int          LEN_W        = 11,
  parameter logic [31:0] DEFAULT_SEED = 32'hACE1_2468
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_length,
  input  logic [31:0]      i_seed,
  input  logic             i_abort,
  input  logic             i_ready,
  output logic [7:0]       o_data,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_byte_count,
  output logic [2:0]       o_dbg_state
);
  import lfsr_prbs_sequencer_pkg::*;

  // Handshake: a byte transfers on a cycle where o_valid and i_ready are both
  // high and i_abort is low; o_data/o_last stay stable while o_valid waits.

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [LEN_W-1:0]       count_q, count_d;
  logic [2:0]             shift_cnt_q, shift_cnt_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   lfsr_load;
  logic                   lfsr_en;
  logic [LFSR_BITS-1:0]   lfsr_data;
  logic                   unused_lfsr_hi;

  lfsr #(
    .NUM_BITS(LFSR_BITS)
  ) u_lfsr (
    .i_clk       (i_clk),
    .i_rst_seed  (lfsr_load),
    .i_enable    (lfsr_en),
    .i_seed_data (safe_seed(i_seed, DEFAULT_SEED)),
    .o_lfsr_data (lfsr_data)
  );

  assign unused_lfsr_hi = ^lfsr_data[LFSR_BITS-1:BITS_PER_BYTE];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      count_q     <= '0;
      shift_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      shift_cnt_q <= shift_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    count_d     = count_q;
    shift_cnt_d = shift_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    lfsr_load   = 1'b0;
    lfsr_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          rem_d       = i_length;
          count_d     = '0;
          shift_cnt_d = '0;
          lfsr_load   = 1'b1;
          state_d     = (i_length == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        lfsr_en     = 1'b1;
        shift_cnt_d = shift_cnt_q + 3'd1;
        if (shift_cnt_q == 3'd7) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        data_d  = lfsr_data[BITS_PER_BYTE-1:0];
        valid_d = 1'b1;
        last_d  = (rem_q == LEN_W'(1));
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (i_ready) begin
          rem_d       = rem_q - LEN_W'(1);
          count_d     = count_q + LEN_W'(1);
          valid_d     = 1'b0;
          last_d      = 1'b0;
          shift_cnt_d = '0;
          state_d     = last_q ? ST_DONE : ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over a same-cycle transfer: the presented byte is not counted.
    if (i_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      rem_d   = rem_q;
      count_d = count_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_last       = last_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);
  assign o_byte_count = count_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_lfsr_prbs_sequencer.sv
// Directed bench for lfsr_prbs_sequencer with an expected-byte scoreboard.
module tb_lfsr_prbs_sequencer;

  localparam int LEN_W = 11;
  localparam logic [31:0] DEF_SEED = 32'hACE1_2468;
  localparam int W = 26; // {timed, cycle[15:0], last, data[7:0]}

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start;
  logic [LEN_W-1:0] i_length;
  logic [31:0]      i_seed;
  logic             i_abort;
  logic             i_ready;
  logic [7:0]       o_data;
  logic             o_valid;
  logic             o_last;
  logic             o_busy;
  logic             o_done;
  logic [LEN_W-1:0] o_byte_count;
  logic [2:0]       o_dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0]  exp_q[$];
  logic [15:0]   done_q[$];

  lfsr_prbs_sequencer #(
    .LEN_W(LEN_W),
    .DEFAULT_SEED(DEF_SEED)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (i_start),
    .i_length     (i_length),
    .i_seed       (i_seed),
    .i_abort      (i_abort),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_byte_count (o_byte_count),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] step8(input logic [31:0] s);
    logic [31:0] r;
    logic fb;
    r = s;
    for (int k = 0; k < 8; k++) begin
      fb = ~(r[31] ^ r[21] ^ r[1] ^ r[0]);
      r  = {r[30:0], fb};
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start_burst(input int len, input logic [31:0] seed, output int base);
    i_start  = 1'b1;
    i_length = LEN_W'(len);
    i_seed   = seed;
    tick();
    i_start  = 1'b0;
    base     = cyc;
  endtask

  // Push bytes idx first..n-1 of a burst; byte i is due in cycle base+9+10*i.
  task automatic push_bytes(input logic [31:0] seed, input int n, input int first,
                            input int base, input logic timed);
    logic [31:0] s;
    s = seed;
    for (int i = 0; i < n; i++) begin
      s = step8(s);
      if (i >= first)
        exp_q.push_back({timed, 16'(base + 9 + 10 * i), (i == n - 1), s[7:0]});
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_busy && n < 400) begin
      tick();
      n++;
    end
    if (o_busy) begin
      errors++;
      $display("FAIL %s: timeout waiting for idle, busy=%0b", name, o_busy);
    end
    tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] ent;
  logic [15:0]  dstamp;
  int           last_xfer = 0;
  logic         stall_prev = 1'b0;
  logic [7:0]   data_prev;
  logic         busy_chk = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      busy_chk   = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid_held", {31'd0, o_valid}, 32'd1);
        chk("stall_data_stable", {24'd0, o_data}, {24'd0, data_prev});
      end
      if (o_last) chk("last_implies_valid", {31'd0, o_valid}, 32'd1);
      if (o_valid && i_ready && !i_abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none (cyc=%0d)", o_data, cyc);
        end else begin
          ent = exp_q.pop_front();
          chk("byte_data", {24'd0, o_data}, {24'd0, ent[7:0]});
          chk("byte_last", {31'd0, o_last}, {31'd0, ent[8]});
          if (ent[25]) chk("byte_cycle", cyc, {16'd0, ent[24:9]});
          if (ent[8]) last_xfer = cyc;
        end
      end
      if (busy_chk) begin
        chk("busy_after_done", {31'd0, o_busy}, 32'd0);
        busy_chk = 1'b0;
      end
      if (o_done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done expected none (cyc=%0d)", cyc);
        end else begin
          dstamp = done_q.pop_front();
          chk("done_cycle", cyc, (dstamp == 16'hFFFF) ? last_xfer + 1 : {16'd0, dstamp});
          busy_chk = 1'b1;
        end
      end
      stall_prev = o_valid && !i_ready && !i_abort;
      data_prev  = o_data;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int base;
    rst = 1'b1; i_start = 1'b0; i_length = '0; i_seed = '0; i_abort = 1'b0; i_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_last", {31'd0, o_last}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_count", {21'd0, o_byte_count}, 32'd0);
    chk("rst_state", {29'd0, o_dbg_state}, 32'd0);
    rst = 1'b0;
    tick();

    // Seed 0, length 1: hand-computed first byte 0x92 in cycle 10.
    start_burst(1, 32'h0, base);
    exp_q.push_back({1'b1, 16'(base + 9), 1'b1, 8'h92});
    done_q.push_back(16'hFFFF);
    wait_idle("len1");
    chk("len1_count", {21'd0, o_byte_count}, 32'd1);

    // Seed 0, length 3: first byte hand value, rest from model.
    start_burst(3, 32'h0, base);
    exp_q.push_back({1'b1, 16'(base + 9), 1'b0, 8'h92});
    push_bytes(32'h0, 3, 1, base, 1'b1);
    done_q.push_back(16'hFFFF);
    wait_idle("len3");
    chk("len3_count", {21'd0, o_byte_count}, 32'd3);

    // Lock-up seed is replaced by the default seed.
    start_burst(1, 32'hFFFF_FFFF, base);
    push_bytes(DEF_SEED, 1, 0, base, 1'b1);
    done_q.push_back(16'hFFFF);
    wait_idle("lockup");

    // Length 2 with a 20-cycle stall in the first PRESENT.
    i_ready = 1'b0;
    start_burst(2, 32'h1234_5678, base);
    push_bytes(32'h1234_5678, 2, 0, base, 1'b0);
    done_q.push_back(16'hFFFF);
    for (int n = 0; n < 50 && !o_valid; n++) tick();
    chk("stall_reached_present", {31'd0, o_valid}, 32'd1);
    repeat (20) tick();
    chk("stall_state", {29'd0, o_dbg_state}, 32'd3);
    i_ready = 1'b1;
    wait_idle("stall");
    chk("stall_count", {21'd0, o_byte_count}, 32'd2);

    // Length 5, abort together with ready in the second PRESENT.
    start_burst(5, 32'h0, base);
    exp_q.push_back({1'b1, 16'(base + 9), 1'b0, 8'h92});
    while (cyc < base + 19) tick();
    chk("abort_second_valid", {31'd0, o_valid}, 32'd1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_valid", {31'd0, o_valid}, 32'd0);
    chk("abort_count", {21'd0, o_byte_count}, 32'd1);
    repeat (5) tick();
    start_burst(1, 32'h0, base);
    exp_q.push_back({1'b1, 16'(base + 9), 1'b1, 8'h92});
    done_q.push_back(16'hFFFF);
    wait_idle("after_abort");

    // Zero length: done in the cycle after start, no bytes.
    start_burst(0, 32'h5555_0000, base);
    done_q.push_back(16'(base));
    wait_idle("len0");
    chk("len0_count", {21'd0, o_byte_count}, 32'd0);

    // Start during SHIFT of an active burst is ignored.
    start_burst(2, 32'hCAFE_0001, base);
    push_bytes(32'hCAFE_0001, 2, 0, base, 1'b1);
    done_q.push_back(16'hFFFF);
    tick(); tick();
    i_start = 1'b1; i_length = LEN_W'(7); i_seed = 32'h0;
    tick();
    i_start = 1'b0;
    wait_idle("ignored_start");
    chk("ignored_start_count", {21'd0, o_byte_count}, 32'd2);
    chk("ignored_start_idle", {31'd0, o_busy}, 32'd0);

    // Reset mid-burst after one byte has transferred.
    start_burst(3, 32'h0, base);
    exp_q.push_back({1'b1, 16'(base + 9), 1'b0, 8'h92});
    while (cyc < base + 12) tick();
    rst = 1'b1;
    #1;
    chk("midrst_count", {21'd0, o_byte_count}, 32'd0);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_state", {29'd0, o_dbg_state}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
